alu_cmd_issue: RTL and testbench
================================

# alu_cmd_issue

Upstream issue stage for the 8-bit `alu`. It accepts operation commands over a valid/ready stream and buffers them in a small FIFO. It drives the ALU's `A`/`B`/`ALU_Sel` inputs one operation at a time, waits out the ALU's registered latency, and captures `ALU_Out`/`CarryOut`. It then presents the captured result, in order, on a valid/ready result stream. Divide-by-zero is trapped here and never issued to the ALU.

## Interface
- `WIDTH`, 8: operand and result width; matches the ALU.
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `ALU_LATENCY`, 1: clock edges from ALU input change to `ALU_Out` update.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; one clock and one reset only.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept.
- `cmd_a` in WIDTH: operand A.
- `cmd_b` in WIDTH: operand B.
- `cmd_sel` in 4: opcode (`alu_pkg` encoding).
- `alu_a` out WIDTH: to ALU `A`.
- `alu_b` out WIDTH: to ALU `B`.
- `alu_sel` out 4: to ALU `ALU_Sel`.
- `alu_out` in WIDTH: from ALU `ALU_Out`.
- `alu_carry` in 1: from ALU `CarryOut`.
- `res_valid` out 1: result present.
- `res_ready` in 1: consumer accepts.
- `res_data` out WIDTH: captured result.
- `res_carry` out 1: captured carry.
- `res_sel` out 4: opcode of this result.
- `res_err` out 1: divide-by-zero trapped.

## Operation
- **Reset values.** All outputs are 0 while `reset` is high. FIFO is emptied and the FSM goes to IDLE. `cmd_ready` is 1 from the first cycle after reset deasserts.
- **Accepting commands.** A command is accepted on an edge where `cmd_valid && cmd_ready`. `cmd_ready = !fifo_full`, derived from the registered count.
- **FIFO push/pop.** Push and pop in the same cycle are legal; count stays unchanged. A push while full is impossible by construction.
- **FSM states:** IDLE, WAIT, HOLD.
- **IDLE, FIFO non-empty:**
  - Pop the head command.
  - If `sel==DIV` and `b==0`: load `res_data=8'hFF`, `res_carry=0`, `res_err=1`, `res_sel=sel`, then go to HOLD. `alu_*` are left unchanged.
  - Otherwise: register `alu_a`/`alu_b`/`alu_sel` from the command, load the wait counter with `ALU_LATENCY+1`, and go to WAIT.
- **WAIT.** Decrement the counter each edge. On the edge where the counter is 1:
  - capture `res_data=alu_out`, `res_carry=alu_carry`, `res_err=0`, `res_sel=alu_sel`;
  - go to HOLD.
- **HOLD.** `res_valid=1`, and all `res_*` are stable. On an edge with `res_ready`: clear `res_valid` and go to IDLE. The next pop happens on the following edge; there is no same-edge pop.
- **ALU input hold.** `alu_*` hold their last value between operations.
- **Ordering.** Results are in strict command order; one operation is in flight at a time.
- **Unknown opcodes (4..15).** Issued to the ALU unchanged; no trap.

## Timing
- **Normal path.** Command accepted at edge t with the FSM in IDLE and the FIFO empty:
  - pop and `alu_*` are valid after edge t+1;
  - capture happens at edge t+2+ALU_LATENCY;
  - `res_valid` is high after edge t+2+ALU_LATENCY, i.e. after t+3 for the default.
- **Trap path.** `res_valid` is high after edge t+1.
- **Throughput.** With `res_ready` tied high, one operation per ALU_LATENCY+3 cycles.
- **Reset mid-operation.** Reset in WAIT or HOLD:
  - the in-flight result is dropped and never presented;
  - `res_valid=0` and the FIFO is empty after the reset edge.
- **Capacity.** Accepted commands stall at DEPTH in the FIFO plus 1 in flight. `cmd_ready` falls in the cycle after the push that fills the FIFO.

## Structure
- **`alu_pkg`:**
  - opcode constants `ALU_ADD=4'b0000`, `ALU_SUB=4'b0001`, `ALU_MUL=4'b0010`, `ALU_DIV=4'b0011`;
  - FSM enum `issue_state_t {IDLE, WAIT, HOLD}`;
  - `WIDTH` default.
- **Sub-module `alu_cmd_fifo`.** A synchronous FIFO with `WIDTH*2+4`-bit entries, DEPTH, and full/empty/count outputs, using wrap-around pointers with an extra MSB.
- **Top.** The FSM, operand registers, wait counter and result registers live in `alu_cmd_issue`.

## Test plan
- **Add, no carry.** Reset, then send `a=10 b=5 sel=ADD` with `res_ready=1` → `res_data=15`, `res_carry=0`, `res_err=0`; `res_valid` rises exactly 3 cycles after acceptance.
- **Add with carry.** `a=200 b=100 sel=ADD` → `res_data=44`, `res_carry=1`.
- **Divide by zero.** `a=20 b=0 sel=DIV` → `res_data=8'hFF`, `res_err=1`; `res_valid` one cycle after acceptance; `alu_*` unchanged from the previous operation.
- **Backpressure.** Hold `res_ready=0` and stream commands → exactly 5 are accepted, then `cmd_ready=0`. Release → five results in order, e.g. ADD 10+5=15, MUL 3×2=6, MUL 4×5=20, DIV 20/4=5, DIV 30/5=6.
- **Reset mid-operation.** Assert reset during WAIT with 2 commands queued → `res_valid` never asserts for them, the FIFO is empty, and `cmd_ready=1` after reset drops.
- **Simultaneous push/pop.** With the FIFO at DEPTH-1, push on the same edge as a pop → count unchanged, `cmd_ready` stays 1, and no command is lost or duplicated.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, issue FSM states and default datapath width
// for the ALU command issue stage.
package alu_pkg;

  localparam int unsigned WIDTH = 8;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } issue_state_t;

  // Divide-by-zero never reaches the ALU; it is answered locally.
  function automatic logic traps_div_zero(input logic [3:0] sel, input logic b_is_zero);
    return (sel == ALU_DIV) && b_is_zero;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with wrap-around pointers (extra MSB) so that
// full and empty are distinguished without a separate flag.
module alu_cmd_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/alu_cmd_issue.sv
// Issue stage in front of the registered ALU: queues commands, issues one
// at a time, waits out the ALU latency and presents results in order.
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH       = alu_pkg::WIDTH,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic [3:0]       res_sel,
  output logic             res_err
);

  localparam int unsigned EW = WIDTH*2 + 4;
  localparam int unsigned CW = $clog2(ALU_LATENCY + 2);

  issue_state_t state_q, state_d;

  logic [EW-1:0]          head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   push;
  logic                   pop;

  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic [3:0]       head_sel;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_d, alu_b_d;
  logic [3:0]       alu_sel_d;
  logic             res_valid_d;
  logic [WIDTH-1:0] res_data_d;
  logic             res_carry_d;
  logic [3:0]       res_sel_d;
  logic             res_err_d;

  // Ready is forced low during reset so every output reads 0 while reset is high.
  assign cmd_ready = !reset && (fifo_count != ($clog2(DEPTH)+1)'(DEPTH));
  assign push      = cmd_valid && cmd_ready;

  alu_cmd_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata ({cmd_sel, cmd_a, cmd_b}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_sel = head[EW-1 -: 4];
  assign head_a   = head[2*WIDTH-1 -: WIDTH];
  assign head_b   = head[WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a;
    alu_b_d     = alu_b;
    alu_sel_d   = alu_sel;
    res_valid_d = res_valid;
    res_data_d  = res_data;
    res_carry_d = res_carry;
    res_sel_d   = res_sel;
    res_err_d   = res_err;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (traps_div_zero(head_sel, head_b == '0)) begin
            res_data_d  = '1;
            res_carry_d = 1'b0;
            res_err_d   = 1'b1;
            res_sel_d   = head_sel;
            res_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            alu_a_d   = head_a;
            alu_b_d   = head_b;
            alu_sel_d = head_sel;
            cnt_d     = CW'(ALU_LATENCY + 1);
            state_d   = WAIT;
          end
        end
      end

      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_data_d  = alu_out;
          res_carry_d = alu_carry;
          res_err_d   = 1'b0;
          res_sel_d   = alu_sel;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_sel   <= '0;
      res_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_sel   <= alu_sel_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
      res_carry <= res_carry_d;
      res_sel   <= res_sel_d;
      res_err   <= res_err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (!(push && fifo_full));
  end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue with a registered one-cycle ALU model.
module tb_alu_cmd_issue;
  import alu_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic [3:0] cmd_sel = '0;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out = '0;
  logic       alu_carry = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_carry;
  logic [3:0] res_sel;
  logic       res_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rise_cyc = 0;
  bit rv_prev = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       carry;
    logic [3:0] sel;
    logic       err;
  } res_t;
  res_t rq[$];

  alu_cmd_issue dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_sel   (res_sel),
    .res_err   (res_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    logic [15:0] p;
    case (s)
      ALU_ADD: return {1'b0, a} + {1'b0, b};
      ALU_SUB: return {1'b0, a - b};
      ALU_MUL: begin p = a * b; return {1'b0, p[7:0]}; end
      ALU_DIV: return (b != 0) ? {1'b0, a / b} : 9'h0FF;
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  always @(posedge clock) {alu_carry, alu_out} <= alu_ref(alu_a, alu_b, alu_sel);

  always @(negedge clock) begin
    if (!reset && res_valid && res_ready)
      rq.push_back('{res_data, res_carry, res_sel, res_err});
    if (res_valid && !rv_prev) rise_cyc = cyc;
    rv_prev = res_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+#1; ok reports whether the command was taken.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                      input int limit, output bit ok);
    ok = 1'b0;
    cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clock);
      if (cmd_ready) begin
        @(posedge clock); #1;
        acc_cyc = cyc;
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int k = 0; k < 200 && rq.size() < n; k++) @(negedge clock);
    check("result_count", rq.size(), n);
    @(posedge clock); #1;
  endtask

  task automatic check_res(input string tag, input int i, input logic [7:0] d,
                           input logic c, input logic [3:0] s, input logic e);
    if (i < rq.size()) begin
      check({tag, "_data"}, rq[i].data, d);
      check({tag, "_carry"}, rq[i].carry, c);
      check({tag, "_sel"}, rq[i].sel, s);
      check({tag, "_err"}, rq[i].err, e);
    end
  endtask

  bit ok;
  int accepted;
  int rv_seen;

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_res_data", res_data, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Add, no carry
    res_ready = 1'b1;
    send(8'd10, 8'd5, ALU_ADD, 10, ok);
    check("add_accept", ok, 1);
    wait_results(1);
    check_res("add", 0, 8'd15, 1'b0, ALU_ADD, 1'b0);
    check("add_latency", rise_cyc - acc_cyc, 3);
    check("add_alu_a", alu_a, 10);
    check("add_alu_b", alu_b, 5);

    // Add with carry
    rq.delete();
    send(8'd200, 8'd100, ALU_ADD, 10, ok);
    wait_results(1);
    check_res("addc", 0, 8'd44, 1'b1, ALU_ADD, 1'b0);

    // Divide by zero trap
    rq.delete();
    send(8'd20, 8'd0, ALU_DIV, 10, ok);
    wait_results(1);
    check_res("div0", 0, 8'hFF, 1'b0, ALU_DIV, 1'b1);
    check("div0_latency", rise_cyc - acc_cyc, 1);
    check("div0_alu_a", alu_a, 200);
    check("div0_alu_b", alu_b, 100);
    check("div0_alu_sel", alu_sel, ALU_ADD);

    // Backpressure: DEPTH queued plus one in flight
    rq.delete();
    res_ready = 1'b0;
    accepted = 0;
    send(8'd10, 8'd5, ALU_ADD, 8, ok); accepted += int'(ok);
    send(8'd3,  8'd2, ALU_MUL, 8, ok); accepted += int'(ok);
    send(8'd4,  8'd5, ALU_MUL, 8, ok); accepted += int'(ok);
    send(8'd20, 8'd4, ALU_DIV, 8, ok); accepted += int'(ok);
    send(8'd30, 8'd5, ALU_DIV, 8, ok); accepted += int'(ok);
    check("bp_ready_after_fill", cmd_ready, 0);
    send(8'd1,  8'd1, ALU_ADD, 8, ok); accepted += int'(ok);
    check("bp_accepted", accepted, 5);
    check("bp_ready_low", cmd_ready, 0);
    res_ready = 1'b1;
    wait_results(5);
    check_res("bp0", 0, 8'd15, 1'b0, ALU_ADD, 1'b0);
    check_res("bp1", 1, 8'd6,  1'b0, ALU_MUL, 1'b0);
    check_res("bp2", 2, 8'd20, 1'b0, ALU_MUL, 1'b0);
    check_res("bp3", 3, 8'd5,  1'b0, ALU_DIV, 1'b0);
    check_res("bp4", 4, 8'd6,  1'b0, ALU_DIV, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    check("bp_no_extra", rq.size(), 5);

    // Reset while in WAIT with two commands queued
    rq.delete();
    send(8'd1, 8'd1, ALU_ADD, 10, ok);
    send(8'd2, 8'd2, ALU_ADD, 10, ok);
    send(8'd3, 8'd3, ALU_ADD, 10, ok);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    rv_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (res_valid) rv_seen++;
    end
    @(posedge clock); #1;
    check("rstmid_no_valid", rv_seen, 0);
    check("rstmid_no_results", rq.size(), 0);
    check("rstmid_cmd_ready", cmd_ready, 1);
    check("rstmid_fifo_count", dut.u_fifo.count, 0);
    send(8'd5, 8'd6, ALU_ADD, 10, ok);
    wait_results(1);
    check_res("rstmid_next", 0, 8'd11, 1'b0, ALU_ADD, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    check("rstmid_single", rq.size(), 1);

    // Push and pop on the same edge with FIFO at DEPTH-1
    rq.delete();
    res_ready = 1'b0;
    send(8'd1,   8'd2,  ALU_ADD, 10, ok);
    send(8'd9,   8'd4,  ALU_SUB, 10, ok);
    send(8'd7,   8'd3,  ALU_MUL, 10, ok);
    send(8'd100, 8'd7,  ALU_DIV, 10, ok);
    res_ready = 1'b1;
    @(posedge clock); #1;
    check("pp_count_before", dut.u_fifo.count, 3);
    check("pp_ready_before", cmd_ready, 1);
    send(8'd250, 8'd10, ALU_ADD, 10, ok);
    check("pp_accept", ok, 1);
    check("pp_count_after", dut.u_fifo.count, 3);
    check("pp_ready_after", cmd_ready, 1);
    wait_results(5);
    check_res("pp0", 0, 8'd3,  1'b0, ALU_ADD, 1'b0);
    check_res("pp1", 1, 8'd5,  1'b0, ALU_SUB, 1'b0);
    check_res("pp2", 2, 8'd21, 1'b0, ALU_MUL, 1'b0);
    check_res("pp3", 3, 8'd14, 1'b0, ALU_DIV, 1'b0);
    check_res("pp4", 4, 8'd4,  1'b1, ALU_ADD, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    check("pp_no_extra", rq.size(), 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
